// File: rtl/usb_hub_upstream_arbiter.sv
// Round-robin, packet-locked arbiter for the hub's upstream transmit path.
// Optional stall timeout enabled by defining USB_HUB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, arbitrating among eligible ports
// GRANT | one port owns the upstream path until packet-last or disable
// GAP   | enforced inter-packet idle before arbitration resumes
module usb_hub_upstream_arbiter #(
  parameter  int NUM_USB_DEVICES = 2,
  parameter  int GAP_CYCLES      = 2,
  parameter  int TIMEOUT_CYCLES  = 1024,
  localparam int GNT_W           = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_USB_DEVICES-1:0] port_enable,
  input  logic [NUM_USB_DEVICES-1:0] port_req,
  input  logic [NUM_USB_DEVICES-1:0] port_val,
  input  logic [NUM_USB_DEVICES-1:0] port_last,
  output logic [NUM_USB_DEVICES-1:0] port_grant,
  output logic                       grant_valid,
  output logic [GNT_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       timeout_abort
);

  localparam int N        = NUM_USB_DEVICES;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam state_t EXIT_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [GNT_W-1:0] grant_id_q, grant_id_d;
  logic [GNT_W-1:0] rr_q, rr_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             tmo_abort_q, tmo_abort_d;

  logic [N-1:0]     elig;
  logic             found;
  logic [GNT_W-1:0] winner;
  logic             g_val, g_last, g_en, g_end, tmo_hit;

  assign elig   = port_req & port_enable;
  assign g_val  = port_val[grant_id_q];
  assign g_last = port_last[grant_id_q];
  assign g_en   = port_enable[grant_id_q];
  assign g_end  = g_val & g_last;

  // First eligible port at or above the pointer, wrapping past N-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[(int'(rr_q) + i) % N]) begin
        found  = 1'b1;
        winner = GNT_W'((int'(rr_q) + i) % N);
      end
    end
  end

`ifdef USB_HUB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Idle-beat counter restarts on every granted beat; zero outside GRANT.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (state_q == GRANT && !g_val) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      tmo_hit   = (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    rr_d        = rr_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = GRANT;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          grant_id_d      = winner;
          rr_d            = GNT_W'((int'(winner) + 1) % N);
        end
      end
      GRANT: begin
        // Packet end beats disable, which beats timeout; only a pure stall pulses.
        if (g_end || !g_en || tmo_hit) begin
          state_d     = EXIT_STATE;
          grant_d     = '0;
          grant_id_d  = '0;
          gap_cnt_d   = '0;
          tmo_abort_d = tmo_hit && !g_end && g_en;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      rr_q        <= '0;
      gap_cnt_q   <= '0;
      tmo_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      rr_q        <= rr_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_abort_q <= tmo_abort_d;
    end
  end

  assign port_grant    = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != IDLE);
  assign timeout_abort = tmo_abort_q;

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// Bench for usb_hub_upstream_arbiter: directed scenarios followed by random traffic,
// all checked against an ownership/cooldown model of the arbitration rules.
module tb_usb_hub_upstream_arbiter;
  localparam int N   = 2;
  localparam int GAP = 2;
  localparam int TMO = 8;
  localparam int GW  = (N > 1) ? $clog2(N) : 1;
`ifdef USB_HUB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  port_enable, port_req, port_val, port_last;
  logic [N-1:0]  port_grant;
  logic          grant_valid;
  logic [GW-1:0] grant_id;
  logic          busy, timeout_abort;

  usb_hub_upstream_arbiter #(
    .NUM_USB_DEVICES(N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .port_enable  (port_enable),
    .port_req     (port_req),
    .port_val     (port_val),
    .port_last    (port_last),
    .port_grant   (port_grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_abort(timeout_abort)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: who owns the path (-1 none), edges of cooldown left, next priority, idle beats.
  int m_owner, m_cool, m_ptr, m_stall;
  bit m_abort;

  logic [N-1:0] r_en, r_req, r_val, r_last;
  logic         r_rst;
  int           gap_seen, vp;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_release();
    m_owner = -1;
    m_cool  = GAP;
  endtask

  task automatic model_step();
    bit done;
    m_abort = 1'b0;
    if (reset) begin
      m_owner = -1;
      m_cool  = 0;
      m_ptr   = 0;
      m_stall = 0;
    end else if (m_owner >= 0) begin
      if (port_val[m_owner] && port_last[m_owner]) model_release();
      else if (!port_enable[m_owner]) model_release();
      else if (TMO_EN) begin
        if (port_val[m_owner]) m_stall = 0;
        else m_stall++;
        if (m_stall == TMO) begin
          model_release();
          m_abort = 1'b1;
        end
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      done = 1'b0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!done && port_req[p] && port_enable[p]) begin
          done    = 1'b1;
          m_owner = p;
          m_ptr   = (p + 1) % N;
          m_stall = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("grant", int'(port_grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    check_val("grant_valid", int'(grant_valid), int'(m_owner >= 0));
    check_val("grant_id", int'(grant_id), (m_owner >= 0) ? m_owner : 0);
    check_val("busy", int'(busy), int'((m_owner >= 0) || (m_cool > 0)));
    check_val("timeout_abort", int'(timeout_abort), int'(m_abort));
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] en, input logic [N-1:0] req,
                       input logic [N-1:0] val, input logic [N-1:0] last);
    reset       = rst;
    port_enable = en;
    port_req    = req;
    port_val    = val;
    port_last   = last;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    m_owner = -1; m_cool = 0; m_ptr = 0; m_stall = 0; m_abort = 1'b0;
    reset = 1'b1; port_enable = '0; port_req = '0; port_val = '0; port_last = '0;

    cycle(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cycle(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("rst_grant", int'(port_grant), 0);
    check_val("rst_busy", int'(busy), 0);

    // Both requesting: port0 first.
    cycle(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("t1_grant", int'(port_grant), 1);
    check_val("t1_id", int'(grant_id), 0);
    check_val("t1_busy", int'(busy), 1);

    // Three-beat packet, then gap, then port1.
    cycle(1'b0, 2'b11, 2'b11, 2'b01, 2'b00);
    cycle(1'b0, 2'b11, 2'b11, 2'b01, 2'b00);
    cycle(1'b0, 2'b11, 2'b11, 2'b01, 2'b01);
    check_val("t2_release", int'(port_grant), 0);
    cycle(1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
    check_val("t2_gap1", int'(port_grant), 0);
    cycle(1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
    check_val("t2_gap2", int'(port_grant), 0);
    cycle(1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
    check_val("t2_next", int'(port_grant), 2);

    // Port1 alone, repeated packets with gap counting.
    for (int p = 0; p < 2; p++) begin
      cycle(1'b0, 2'b11, 2'b10, 2'b10, 2'b10);
      gap_seen = 0;
      for (int k = 0; k < 10 && !grant_valid; k++) begin
        if (busy) gap_seen++;
        cycle(1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
      end
      check_val("t3_gap_cycles", gap_seen, GAP);
      check_val("t3_port1", int'(port_grant), 2);
    end

    // Port0 disabled never wins; disabling the owner aborts into the gap.
    cycle(1'b0, 2'b11, 2'b00, 2'b10, 2'b10);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 2'b10, 2'b11, 2'b00, 2'b00);
      check_val("t4_no_port0", int'(port_grant[0]), 0);
    end
    check_val("t4_port1", int'(port_grant), 2);
    cycle(1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
    check_val("t4_abort_grant", int'(port_grant), 0);
    check_val("t4_abort_busy", int'(busy), 1);
    check_val("t4_no_pulse", int'(timeout_abort), 0);

    // Reset during a grant, then port0 wins first again.
    for (int k = 0; k < 10 && !grant_valid; k++) cycle(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("t6_granted", int'(grant_valid), 1);
    cycle(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("t6_rst_grant", int'(port_grant), 0);
    check_val("t6_rst_id", int'(grant_id), 0);
    check_val("t6_rst_busy", int'(busy), 0);
    cycle(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("t6_port0_first", int'(port_grant), 1);

    // Stall after one beat: timeout pulse (when built in) after TMO idle edges.
    cycle(1'b0, 2'b11, 2'b11, 2'b01, 2'b00);
    for (int k = 0; k < TMO; k++) begin
      cycle(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
      check_val("t5_abort", int'(timeout_abort), int'(TMO_EN && (k == TMO - 1)));
    end
    check_val("t5_grant_after", int'(port_grant), TMO_EN ? 0 : 1);
    cycle(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    check_val("t5_one_shot", int'(timeout_abort), 0);

    // Random traffic: busy beats first, then sparse beats to provoke stalls.
    cycle(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 4000; i++) begin
      vp    = (i < 2000) ? 60 : 8;
      r_rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++) begin
        r_en[b]   = ($urandom_range(0, 99) < 93);
        r_req[b]  = ($urandom_range(0, 99) < 70);
        r_val[b]  = ($urandom_range(0, 99) < vp);
        r_last[b] = ($urandom_range(0, 99) < 30);
      end
      cycle(r_rst, r_en, r_req, r_val, r_last);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
